stream64b_to_32b_writer: RTL and testbench
==========================================

Name: stream64b_to_32b_writer

Overview:
- Downstream writeback stage for the MAC array output path.
- Accepts N_DIM_ARRAY-lane (64-bit) activation words with a 32-bit byte address and buffers them in a small FIFO.
- Serializes each word into two 32-bit beats for the 32-bit TCDM/activation memory port, under a valid/grant handshake.
- Mirror of the 32b-to-64b packing stage: lanes 0..3 (low half) go out first, lanes 4..7 (high half) second.

Parameters:
- ACT_DATA_WIDTH, 8, bits per activation lane.
- N_DIM_ARRAY, 8, lanes per input word; must be even.
- FIFO_DEPTH, 2, input word entries; power of two, at least 2.
- ADDR_STEP, 4, byte offset added to input_addr for the high-half beat.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- input_en  in  1  input word valid.
- input_word  in  N_DIM_ARRAY*ACT_DATA_WIDTH  signed packed lanes; lane i is at bits [i*ACT_DATA_WIDTH +: ACT_DATA_WIDTH].
- input_addr  in  32  byte address of the low half.
- input_ready  out  1  FIFO can accept a word this cycle.
- output_word  out  (N_DIM_ARRAY/2)*ACT_DATA_WIDTH  signed 32-bit beat.
- output_addr  out  32  beat address.
- output_en  out  1  beat valid (memory request).
- output_gnt  in  1  memory accepted the beat this cycle.

Behaviour:
- Clocking and reset: one clock domain; reset is asynchronous, active-low.
- Reset values: FIFO empty, phase=LOW, input_ready=1, output_en=0, output_word=0, output_addr=0.
- Push: occurs when input_en && input_ready.
  - Word and address are written to the tail entry.
  - input_en while input_ready=0 is dropped; the upstream stage must hold it. Not an error.
- input_ready = !full.
  - Combinational from registered occupancy only, never from output_gnt, so there is no combinational path from output_gnt to input_ready.
- Phase FSM per head entry:
  - LOW: output_word = head lanes 0..N/2-1; output_addr = head addr.
  - HIGH: output_word = head lanes N/2..N-1; output_addr = head addr + ADDR_STEP, 32-bit wraparound.
  - LOW -> HIGH on output_en && output_gnt.
  - HIGH -> LOW on output_en && output_gnt; the head entry is popped in the same cycle.
- output_en = !empty. output_word and output_addr are driven from FIFO storage plus the phase mux.
- Beat stability: while output_en=1 and output_gnt=0, output_word, output_addr and phase are held stable.
- Latency: a word pushed in cycle t presents its LOW beat at t+1 at the earliest. No same-cycle bypass.
- Throughput: with output_gnt tied high, one beat per cycle, so one input word is accepted every 2 cycles in steady state.
- FIFO_DEPTH=2 absorbs a single-cycle gnt bubble.
- Simultaneous push and HIGH-beat pop:
  - Both take effect and occupancy is unchanged.
  - When full, push cannot occur because input_ready=0. A pop in that cycle lifts input_ready in the next cycle.
- Empty: output_en=0; output_word and output_addr hold their last values; phase stays LOW.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH) bits with natural wrap. Full/empty come from an occupancy counter of log2(FIFO_DEPTH)+1 bits.
- Reset mid-operation flushes the FIFO and phase asynchronously. A partially emitted word (LOW already granted) is discarded and its HIGH beat is never issued.
- output_gnt while output_en=0 is ignored.

Optional Feature:
- Macro: STREAM64B_TO_32B_STATS_EN.
- When defined, adds two outputs:
  - stat_beats, 32 bits, counts output_en && output_gnt.
  - stat_stall, 32 bits, counts output_en && !output_gnt.
- Both counters reset to 0, saturate at 2^32-1, and are cleared by reset only.
- When undefined, the ports and logic are absent and the interface is exactly as listed above.

Decomposition:
- Shared parameters package holds ACT_DATA_WIDTH, N_DIM_ARRAY, and the derived widths for the 64-bit word and the 32-bit half.
- One sub-module: stream_fifo (synchronous FIFO, width and depth parameters, push/pop/full/empty/head). It stores {addr, word}.
- The phase FSM and half-select mux live in the top module.

Test Plan:
- Single word: push word 0x8877665544332211 at addr 0x100 with gnt=1 -> beats 0x44332211@0x100, then 0x88776655@0x104 on consecutive cycles; input_ready stays 1.
- Streaming: 8 back-to-back words, gnt=1 -> 16 beats with no gap, ordered low/high with correct addresses; input_ready toggles so that one word is accepted per 2 cycles.
- Stall: gnt=0 for 5 cycles during a HIGH beat -> word, addr and en are held stable; FIFO fills to 2; input_ready=0; data resumes intact when gnt=1.
- Wraparound: addr 0xFFFFFFFC -> HIGH beat at 0x00000000.
- Reset mid-word: assert reset after a granted LOW beat -> output_en=0 immediately; FIFO empty; no HIGH beat follows; the next push starts at LOW.
- With STREAM64B_TO_32B_STATS_EN: 3 words with 4 stall cycles -> stat_beats=6, stat_stall=4.

Source files
------------

// File: rtl/stream64b_to_32b_writer_pkg.sv
// Shared widths, FIFO entry payload and phase encoding for the 64b->32b writer.
package stream64b_to_32b_writer_pkg;

  localparam int unsigned ACT_DATA_WIDTH = 8;
  localparam int unsigned N_DIM_ARRAY    = 8;
  localparam int unsigned WORD_W         = N_DIM_ARRAY * ACT_DATA_WIDTH;
  localparam int unsigned HALF_W         = (N_DIM_ARRAY / 2) * ACT_DATA_WIDTH;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned STAT_W         = 32;
  localparam int unsigned FIFO_DEPTH_DEF = 2;
  localparam int unsigned ADDR_STEP_DEF  = 4;

  // One buffered input word with the byte address of its low half
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] word;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_e;

  // Select lanes 0..N/2-1 (hi=0) or lanes N/2..N-1 (hi=1)
  function automatic logic [HALF_W-1:0] half_sel(input logic [WORD_W-1:0] w, input logic hi);
    return hi ? w[WORD_W-1 -: HALF_W] : w[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/stream64b_to_32b_writer_stream_fifo.sv
// stream_fifo: synchronous FIFO with registered occupancy and naturally
// wrapping pointers. Head entry is visible whenever empty_o is low.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write data_i at tail (ignored when full)
//   pop_i      : drop head entry (ignored when empty)
//   data_i     : entry to write
//   head_o     : entry at head
//   full_o     : occupancy == DEPTH
//   empty_o    : occupancy == 0
module stream_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/stream64b_to_32b_writer.sv
// stream64b_to_32b_writer: buffers N_DIM_ARRAY-lane activation words and
// serializes each into a low-half beat (at input_addr) followed by a
// high-half beat (at input_addr + ADDR_STEP) under a valid/grant handshake.
//   clk, reset   : clock, asynchronous active-low reset
//   input_en     : input word valid; accepted when input_ready is high
//   input_word   : packed lanes, lane i at [i*ACT_DATA_WIDTH +: ACT_DATA_WIDTH]
//   input_addr   : byte address of the low half
//   input_ready  : FIFO not full (from registered occupancy only)
//   output_word  : current 32-bit beat
//   output_addr  : current beat address
//   output_en    : beat valid (FIFO not empty)
//   output_gnt   : memory accepted the beat
// Optional STREAM64B_TO_32B_STATS_EN adds saturating counters:
//   stat_beats   : granted beats
//   stat_stall   : cycles with a beat presented but not granted
module stream64b_to_32b_writer
  import stream64b_to_32b_writer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned ADDR_STEP  = ADDR_STEP_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     input_en,
  input  logic signed [WORD_W-1:0] input_word,
  input  logic        [ADDR_W-1:0] input_addr,
  output logic                     input_ready,
  output logic signed [HALF_W-1:0] output_word,
  output logic        [ADDR_W-1:0] output_addr,
  output logic                     output_en,
  input  logic                     output_gnt
`ifdef STREAM64B_TO_32B_STATS_EN
  ,
  output logic        [STAT_W-1:0] stat_beats,
  output logic        [STAT_W-1:0] stat_stall
`endif
);

  entry_t             push_entry;
  entry_t             head;
  logic               fifo_full, fifo_empty;
  logic               push, pop_c, beat_fire;
  phase_e             phase_q, phase_d;
  logic [HALF_W-1:0]  cur_word;
  logic [ADDR_W-1:0]  cur_addr;
  logic [HALF_W-1:0]  hold_word_q;
  logic [ADDR_W-1:0]  hold_addr_q;

  assign push_entry = '{addr: input_addr, word: input_word};
  assign input_ready = !fifo_full;
  assign push        = input_en && input_ready;
  assign output_en   = !fifo_empty;
  assign beat_fire   = output_en && output_gnt;

  stream_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop_c),
    .data_i  (push_entry),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Phase state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) phase_q <= PH_LOW;
    else        phase_q <= phase_d;
  end

  // Phase next state; the head is popped when its high beat is granted
  always_comb begin
    phase_d = phase_q;
    pop_c   = 1'b0;
    if (beat_fire) begin
      case (phase_q)
        PH_LOW:  phase_d = PH_HIGH;
        PH_HIGH: begin
          phase_d = PH_LOW;
          pop_c   = 1'b1;
        end
        default: phase_d = PH_LOW;
      endcase
    end
  end

  // Half-select mux; address wraps at 32 bits
  assign cur_word = half_sel(head.word, phase_q == PH_HIGH);
  assign cur_addr = (phase_q == PH_HIGH) ? (head.addr + ADDR_W'(ADDR_STEP)) : head.addr;

  // Last presented beat, so the outputs hold their value while empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_word_q <= '0;
      hold_addr_q <= '0;
    end else if (!fifo_empty) begin
      hold_word_q <= cur_word;
      hold_addr_q <= cur_addr;
    end
  end

  assign output_word = fifo_empty ? hold_word_q : cur_word;
  assign output_addr = fifo_empty ? hold_addr_q : cur_addr;

`ifdef STREAM64B_TO_32B_STATS_EN
  logic [STAT_W-1:0] beats_q, stall_q;

  // Saturating beat/stall counters, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beats_q <= '0;
      stall_q <= '0;
    end else begin
      if (beat_fire && (beats_q != '1)) beats_q <= beats_q + STAT_W'(1);
      if (output_en && !output_gnt && (stall_q != '1)) stall_q <= stall_q + STAT_W'(1);
    end
  end

  assign stat_beats = beats_q;
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_stream64b_to_32b_writer.sv
// Directed bench with a beat scoreboard for stream64b_to_32b_writer.
module tb_stream64b_to_32b_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        input_en;
  logic [63:0] input_word;
  logic [31:0] input_addr;
  logic        input_ready;
  logic [31:0] output_word;
  logic [31:0] output_addr;
  logic        output_en;
  logic        output_gnt;
`ifdef STREAM64B_TO_32B_STATS_EN
  logic [31:0] stat_beats;
  logic [31:0] stat_stall;
`endif

  typedef struct {
    logic [31:0] w;
    logic [31:0] a;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    beat_n, beat_first, beat_last;
  int    m_beats, m_stall;
  int    acc_cyc[$];
  logic  last_acc;

  always #5 clk = ~clk;

  stream64b_to_32b_writer dut (
    .clk         (clk),
    .reset       (rst_n),
    .input_en    (input_en),
    .input_word  (input_word),
    .input_addr  (input_addr),
    .input_ready (input_ready),
    .output_word (output_word),
    .output_addr (output_addr),
    .output_en   (output_en),
    .output_gnt  (output_gnt)
`ifdef STREAM64B_TO_32B_STATS_EN
    ,
    .stat_beats  (stat_beats),
    .stat_stall  (stat_stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes at negedge, return 1 time unit after posedge
  task automatic cycle();
    beat_t b;
    @(negedge clk);
    last_acc = 1'b0;
    if (output_en === 1'b1 && output_gnt === 1'b1) begin
      beat_n++;
      if (beat_first < 0) beat_first = cyc;
      beat_last = cyc;
      m_beats++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL beat_unexpected observed=%h@%h expected=none", output_word, output_addr);
      end
      if (sb.size() != 0) begin
        b = sb.pop_front();
        chk("beat_word", output_word, b.w);
        chk("beat_addr", output_addr, b.a);
      end
    end
    if (output_en === 1'b1 && output_gnt === 1'b0) m_stall++;
    if (input_en === 1'b1 && input_ready === 1'b1) begin
      last_acc = 1'b1;
      acc_cyc.push_back(cyc);
      sb.push_back('{w: input_word[31:0],  a: input_addr});
      sb.push_back('{w: input_word[63:32], a: input_addr + 32'd4});
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      cycle();
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Hold a word on the input until accepted (bounded), then drop input_en
  task automatic send(input logic [63:0] w, input logic [31:0] a);
    int n = 0;
    input_en   = 1'b1;
    input_word = w;
    input_addr = a;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 50);
    chk("send_accepted", 32'(last_acc), 32'd1);
    input_en = 1'b0;
  endtask

  initial begin
    logic [31:0] hw, ha;
    rst_n      = 1'b0;
    input_en   = 1'b0;
    input_word = '0;
    input_addr = '0;
    output_gnt = 1'b0;
    m_beats    = 0;
    m_stall    = 0;
    beat_n     = 0;
    beat_first = -1;
    beat_last  = -1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(input_ready), 32'd1);
    chk("rst_en",    32'(output_en),   32'd0);
    chk("rst_word",  output_word,      32'd0);
    chk("rst_addr",  output_addr,      32'd0);
    rst_n = 1'b1;
    cycle();

    // Single word
    output_gnt = 1'b1;
    input_en   = 1'b1;
    input_word = 64'h8877665544332211;
    input_addr = 32'h100;
    cycle();
    input_en = 1'b0;
    chk("lat_en", 32'(output_en), 32'd1);
    chk("lat_low_word", output_word, 32'h44332211);
    chk("lat_low_addr", output_addr, 32'h100);
    chk("single_ready", 32'(input_ready), 32'd1);
    cycle();
    chk("single_high_word", output_word, 32'h88776655);
    chk("single_high_addr", output_addr, 32'h104);
    chk("single_ready2", 32'(input_ready), 32'd1);
    drain();
    chk("empty_en", 32'(output_en), 32'd0);
    chk("empty_hold_word", output_word, 32'h88776655);
    chk("empty_hold_addr", output_addr, 32'h104);

    // Streaming: 8 back-to-back words
    beat_n = 0; beat_first = -1; beat_last = -1;
    acc_cyc.delete();
    for (int i = 0; i < 8; i++)
      send({32'hA000_0000 | 32'(i), 32'h5000_0000 | 32'(i)}, 32'h1000 + 32'(i * 8));
    drain();
    chk("stream_beats", 32'(beat_n), 32'd16);
    chk("stream_nogap", 32'(beat_last - beat_first + 1), 32'd16);
    chk("stream_accepts", 32'(acc_cyc.size()), 32'd8);
    if (acc_cyc.size() == 8)
      chk("stream_rate", 32'(acc_cyc[7] - acc_cyc[1]), 32'd12);

    // Stall during a HIGH beat
    send(64'h1111_2222_3333_4444, 32'h2000);
    input_en   = 1'b1;
    input_word = 64'h5555_6666_7777_8888;
    input_addr = 32'h2008;
    cycle();
    output_gnt = 1'b0;
    input_word = 64'h9999_AAAA_BBBB_CCCC;
    input_addr = 32'h2010;
    hw = output_word;
    ha = output_addr;
    chk("stall_pre_word", hw, 32'h1111_2222);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_en",    32'(output_en),   32'd1);
      chk("stall_word",  output_word,      hw);
      chk("stall_addr",  output_addr,      ha);
      chk("stall_ready", 32'(input_ready), 32'd0);
    end
    output_gnt = 1'b1;
    send(64'h9999_AAAA_BBBB_CCCC, 32'h2010);
    drain();

    // Address wraparound
    send(64'hDEAD_BEEF_0BAD_F00D, 32'hFFFF_FFFC);
    drain();
    chk("wrap_addr", output_addr, 32'h0000_0000);
    chk("wrap_word", output_word, 32'hDEAD_BEEF);

    // Reset after a granted LOW beat
    input_en   = 1'b1;
    input_word = 64'h0102_0304_0506_0708;
    input_addr = 32'h3000;
    cycle();
    input_en = 1'b0;
    cycle();
    chk("mid_phase_high_addr", output_addr, 32'h3004);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en",    32'(output_en),   32'd0);
    chk("mid_rst_ready", 32'(input_ready), 32'd1);
    chk("mid_rst_word",  output_word,      32'd0);
    sb.delete();
    m_beats = 0;
    m_stall = 0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("mid_idle_en", 32'(output_en), 32'd0);
    end
    input_en   = 1'b1;
    input_word = 64'hCAFE_F00D_1234_5678;
    input_addr = 32'h4000;
    cycle();
    input_en = 1'b0;
    chk("post_rst_low_addr", output_addr, 32'h4000);
    chk("post_rst_low_word", output_word, 32'h1234_5678);
    drain();

`ifdef STREAM64B_TO_32B_STATS_EN
    // Statistics: 3 words, 4 stall cycles
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_beats = 0;
    m_stall = 0;
    chk("stat_rst_beats", stat_beats, 32'd0);
    output_gnt = 1'b0;
    send(64'h0000_0001_0000_0002, 32'h5000);
    send(64'h0000_0003_0000_0004, 32'h5008);
    input_en   = 1'b1;
    input_word = 64'h0000_0005_0000_0006;
    input_addr = 32'h5010;
    repeat (3) cycle();
    output_gnt = 1'b1;
    send(64'h0000_0005_0000_0006, 32'h5010);
    drain();
    chk("stat_beats", stat_beats, 32'd6);
    chk("stat_stall", stat_stall, 32'd4);
    chk("stat_beats_model", stat_beats, 32'(m_beats));
    chk("stat_stall_model", stat_stall, 32'(m_stall));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
